// File: rtl/mcpu_pkg.sv
// mcpu_pkg: shared constants for the multicycle CPU control path.
// State codes, opcode/funct values, ALU_operation codes and datapath
// mux-select encodings. The JAL state code exists only when M_CTRL_JAL_EN
// is defined.
package mcpu_pkg;

    // FSM state encoding
    typedef logic [3:0] state_t;

    localparam state_t S_IF       = 4'd0;
    localparam state_t S_ID       = 4'd1;
    localparam state_t S_MEM_ADDR = 4'd2;
    localparam state_t S_MEM_RD   = 4'd3;
    localparam state_t S_LW_WB    = 4'd4;
    localparam state_t S_MEM_WR   = 4'd5;
    localparam state_t S_R_EXE    = 4'd6;
    localparam state_t S_R_WB     = 4'd7;
    localparam state_t S_I_EXE    = 4'd8;
    localparam state_t S_I_WB     = 4'd9;
    localparam state_t S_LUI_WB   = 4'd10;
    localparam state_t S_BRANCH   = 4'd11;
    localparam state_t S_JUMP     = 4'd12;
    localparam state_t S_HALT     = 4'd13;
`ifdef M_CTRL_JAL_EN
    localparam state_t S_JAL      = 4'd14;
`endif

    // Opcodes (Inst[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    // R-type funct codes (Inst[5:0])
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_SRL = 6'b000010;

    // ALU_operation codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // RegDst select
    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    // MemtoReg select
    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_LUI = 2'b10;
    localparam logic [1:0] M2R_PC  = 2'b11;

    // ALUSrcB select
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    // PCSource select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that stall on MIO_ready and therefore feed the wait counter.
    function automatic logic is_wait_state(input state_t s);
        logic w;
        w = (s == S_IF) || (s == S_MEM_RD) || (s == S_MEM_WR) ||
            (s == S_BRANCH) || (s == S_JUMP);
`ifdef M_CTRL_JAL_EN
        // JAL also stalls on the bus, so a hung bus there must time out too.
        w = w || (s == S_JAL);
`endif
        return w;
    endfunction

endpackage

// File: rtl/m_ctrl_fsm_alu_dec.sv
// m_alu_dec: combinational ALU_operation decode from opcode and funct.
// For R-type it also reports whether the funct is a supported one.
module m_alu_dec
    import mcpu_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_op_o,
    output logic       funct_legal_o
);

    // Map R-type funct or I-type opcode to the ALU operation
    always_comb begin
        alu_op_o      = ALU_ADD;
        funct_legal_o = 1'b0;
        if (opcode_i == OP_RTYPE) begin
            funct_legal_o = 1'b1;
            case (funct_i)
                F_ADD:   alu_op_o = ALU_ADD;
                F_SUB:   alu_op_o = ALU_SUB;
                F_AND:   alu_op_o = ALU_AND;
                F_OR:    alu_op_o = ALU_OR;
                F_XOR:   alu_op_o = ALU_XOR;
                F_NOR:   alu_op_o = ALU_NOR;
                F_SLT:   alu_op_o = ALU_SLT;
                F_SRL:   alu_op_o = ALU_SRL;
                default: funct_legal_o = 1'b0;
            endcase
        end else begin
            case (opcode_i)
                OP_ANDI: alu_op_o = ALU_AND;
                OP_ORI:  alu_op_o = ALU_OR;
                OP_SLTI: alu_op_o = ALU_SLT;
                default: alu_op_o = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/m_ctrl_fsm.sv
// m_ctrl_fsm: Moore control FSM for a multicycle MIPS-like datapath.
// Bus waits are counted; reaching BUS_TIMEOUT (non-zero) locks the FSM in
// HALT with bus_err until reset. Optional macro M_CTRL_JAL_EN adds jal.
// Outputs are forced to 0 while reset is low so a reset mid-instruction
// drops every write enable immediately.
module m_ctrl_fsm
    import mcpu_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Inst,
    input  logic        zero,
    input  logic        MIO_ready,
    output logic        IorD,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        Branch,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic [2:0]  ALU_operation,
    output logic        illegal_inst,
    output logic        bus_err,
    output state_t      state_dbg_o
);

    localparam logic [7:0] TIMEOUT_C  = 8'(BUS_TIMEOUT);
    localparam bit         TIMEOUT_EN = (BUS_TIMEOUT != 0);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [7:0] wait_cnt_inc;
    logic       stall;
    logic       illegal_d;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [2:0] dec_alu_op;
    logic       dec_funct_legal;

    // zero is consumed by the datapath (PCWriteCond & zero); the middle
    // instruction bits are not needed for control.
    logic unused_inputs;
    assign unused_inputs = ^{Inst[25:6], zero};

    assign opcode      = Inst[31:26];
    assign funct       = Inst[5:0];
    assign state_dbg_o = state_q;

    m_alu_dec u_alu_dec (
        .opcode_i      (opcode),
        .funct_i       (funct),
        .alu_op_o      (dec_alu_op),
        .funct_legal_o (dec_funct_legal)
    );

    // Saturating increment and stall detection for the bus wait counter
    always_comb begin
        wait_cnt_inc = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
        stall        = is_wait_state(state_q) && !MIO_ready;
        wait_cnt_d   = stall ? wait_cnt_inc : 8'd0;
    end

    // Next-state logic, including ID decode and bus timeout
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            S_IF:       if (MIO_ready) state_d = S_ID;
            S_ID: begin
                case (opcode)
                    OP_RTYPE: begin
                        if (dec_funct_legal) state_d = S_R_EXE;
                        else                 illegal_d = 1'b1;
                    end
                    OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
                    OP_J:                              state_d = S_JUMP;
`ifdef M_CTRL_JAL_EN
                    OP_JAL:                            state_d = S_JAL;
`endif
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_I_EXE;
                    OP_LUI:                            state_d = S_LUI_WB;
                    default:                           illegal_d = 1'b1;
                endcase
                if (illegal_d) state_d = S_IF;
            end
            S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (MIO_ready) state_d = S_LW_WB;
            S_LW_WB:    state_d = S_IF;
            S_MEM_WR:   if (MIO_ready) state_d = S_IF;
            S_R_EXE:    state_d = S_R_WB;
            S_R_WB:     state_d = S_IF;
            S_I_EXE:    state_d = S_I_WB;
            S_I_WB:     state_d = S_IF;
            S_LUI_WB:   state_d = S_IF;
            S_BRANCH:   if (MIO_ready) state_d = S_IF;
            S_JUMP:     if (MIO_ready) state_d = S_IF;
`ifdef M_CTRL_JAL_EN
            S_JAL:      if (MIO_ready) state_d = S_IF;
`endif
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_IF;
        endcase
        if (TIMEOUT_EN && stall && (wait_cnt_inc == TIMEOUT_C)) begin
            state_d = S_HALT;
        end
    end

    // State and wait counter registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IF;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Moore output decode, all zero while reset is held
    always_comb begin
        IorD          = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        Branch        = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        RegDst        = REGDST_RT;
        MemtoReg      = M2R_ALU;
        ALUSrcB       = SRCB_REG;
        PCSource      = PCSRC_ALU;
        ALU_operation = ALU_AND;
        illegal_inst  = 1'b0;
        bus_err       = 1'b0;
        if (reset) begin
            case (state_q)
                S_IF: begin
                    MemRead       = 1'b1;
                    IRWrite       = 1'b1;
                    ALUSrcB       = SRCB_FOUR;
                    ALU_operation = ALU_ADD;
                    PCSource      = PCSRC_ALU;
                    PCWrite       = 1'b1;
                end
                S_ID: begin
                    ALUSrcB       = SRCB_BOFF;
                    ALU_operation = ALU_ADD;
                    illegal_inst  = illegal_d;
                end
                S_MEM_ADDR: begin
                    ALUSrcA       = 1'b1;
                    ALUSrcB       = SRCB_IMM;
                    ALU_operation = ALU_ADD;
                end
                S_MEM_RD: begin
                    ALUSrcA       = 1'b1;
                    ALUSrcB       = SRCB_IMM;
                    ALU_operation = ALU_ADD;
                    IorD          = 1'b1;
                    MemRead       = 1'b1;
                end
                S_LW_WB: begin
                    RegDst   = REGDST_RT;
                    MemtoReg = M2R_MEM;
                    RegWrite = 1'b1;
                end
                S_MEM_WR: begin
                    ALUSrcA       = 1'b1;
                    ALUSrcB       = SRCB_IMM;
                    ALU_operation = ALU_ADD;
                    IorD          = 1'b1;
                    MemWrite      = 1'b1;
                end
                S_R_EXE: begin
                    ALUSrcA       = 1'b1;
                    ALUSrcB       = SRCB_REG;
                    ALU_operation = dec_alu_op;
                end
                S_R_WB: begin
                    RegDst   = REGDST_RD;
                    MemtoReg = M2R_ALU;
                    RegWrite = 1'b1;
                end
                S_I_EXE: begin
                    ALUSrcA       = 1'b1;
                    ALUSrcB       = SRCB_IMM;
                    ALU_operation = dec_alu_op;
                end
                S_I_WB: begin
                    RegDst   = REGDST_RT;
                    MemtoReg = M2R_ALU;
                    RegWrite = 1'b1;
                end
                S_LUI_WB: begin
                    RegDst   = REGDST_RT;
                    MemtoReg = M2R_LUI;
                    RegWrite = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA       = 1'b1;
                    ALUSrcB       = SRCB_REG;
                    ALU_operation = ALU_SUB;
                    PCWriteCond   = 1'b1;
                    PCSource      = PCSRC_ALUOUT;
                    Branch        = (opcode == OP_BEQ);
                end
                S_JUMP: begin
                    PCSource = PCSRC_JUMP;
                    PCWrite  = 1'b1;
                end
`ifdef M_CTRL_JAL_EN
                S_JAL: begin
                    PCSource = PCSRC_JUMP;
                    PCWrite  = 1'b1;
                    RegDst   = REGDST_RA;
                    MemtoReg = M2R_PC;
                    RegWrite = 1'b1;
                end
`endif
                S_HALT: begin
                    bus_err = 1'b1;
                end
                default: begin
                    bus_err = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_ctrl_fsm.sv
// tb_m_ctrl_fsm: directed bench for m_ctrl_fsm (BUS_TIMEOUT = 4).
// Each cycle sets MIO_ready, then compares state and the packed control
// vector against hand-written expected values mid-cycle.
module tb_m_ctrl_fsm;
    import mcpu_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] Inst;
    logic        zero;
    logic        MIO_ready;
    logic        IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond;
    logic        Branch, MemRead, MemWrite;
    logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
    logic [2:0]  ALU_operation;
    logic        illegal_inst, bus_err;
    state_t      state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    // Packed control vector:
    // {IorD,IRWrite,RegWrite,ALUSrcA,PCWrite,PCWriteCond,Branch,MemRead,
    //  MemWrite,RegDst[2],MemtoReg[2],ALUSrcB[2],PCSource[2],ALU[3],ill,berr}
    logic [21:0] ctrl_w;
    assign ctrl_w = {IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond,
                     Branch, MemRead, MemWrite, RegDst, MemtoReg, ALUSrcB,
                     PCSource, ALU_operation, illegal_inst, bus_err};

    //                                  IoD IRW RW  ASA PCW PWC Br  MR  MW  RD    M2R   ASB   PCS   ALU     ill berr
    localparam logic [21:0] E_ZERO  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,3'b000,1'b0,1'b0};
    localparam logic [21:0] E_IF    = {1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b01,2'b00,3'b010,1'b0,1'b0};
    localparam logic [21:0] E_ID    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b11,2'b00,3'b010,1'b0,1'b0};
    localparam logic [21:0] E_ILL   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b11,2'b00,3'b010,1'b1,1'b0};
    localparam logic [21:0] E_MADDR = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,2'b00,3'b010,1'b0,1'b0};
    localparam logic [21:0] E_MRD   = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b10,2'b00,3'b010,1'b0,1'b0};
    localparam logic [21:0] E_LWWB  = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b00,2'b00,3'b000,1'b0,1'b0};
    localparam logic [21:0] E_MWR   = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b10,2'b00,3'b010,1'b0,1'b0};
    localparam logic [21:0] E_RSUB  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,3'b110,1'b0,1'b0};
    localparam logic [21:0] E_RSRL  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,3'b101,1'b0,1'b0};
    localparam logic [21:0] E_RWB   = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,2'b00,3'b000,1'b0,1'b0};
    localparam logic [21:0] E_IORI  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,2'b00,3'b001,1'b0,1'b0};
    localparam logic [21:0] E_ISLT  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,2'b00,3'b111,1'b0,1'b0};
    localparam logic [21:0] E_IWB   = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,3'b000,1'b0,1'b0};
    localparam logic [21:0] E_LUI   = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b00,3'b000,1'b0,1'b0};
    localparam logic [21:0] E_BEQ   = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,2'b01,3'b110,1'b0,1'b0};
    localparam logic [21:0] E_BNE   = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b01,3'b110,1'b0,1'b0};
    localparam logic [21:0] E_JUMP  = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b10,3'b000,1'b0,1'b0};
    localparam logic [21:0] E_JAL   = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b10,2'b11,2'b00,2'b10,3'b000,1'b0,1'b0};
    localparam logic [21:0] E_HALT  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,3'b000,1'b0,1'b1};

    m_ctrl_fsm #(.BUS_TIMEOUT(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .Inst          (Inst),
        .zero          (zero),
        .MIO_ready     (MIO_ready),
        .IorD          (IorD),
        .IRWrite       (IRWrite),
        .RegWrite      (RegWrite),
        .ALUSrcA       (ALUSrcA),
        .PCWrite       (PCWrite),
        .PCWriteCond   (PCWriteCond),
        .Branch        (Branch),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .RegDst        (RegDst),
        .MemtoReg      (MemtoReg),
        .ALUSrcB       (ALUSrcB),
        .PCSource      (PCSource),
        .ALU_operation (ALU_operation),
        .illegal_inst  (illegal_inst),
        .bus_err       (bus_err),
        .state_dbg_o   (state_dbg)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Load an instruction; the unused middle bits are randomised
    task automatic set_inst(input logic [5:0] op, input logic [5:0] fn);
        Inst = {op, 20'($urandom_range(0, 20'hFFFFF)), fn};
    endtask

    // One cycle: drive MIO_ready, check state/controls, advance to next cycle
    task automatic cyc(input string tag, input logic rdy, input state_t es, input logic [21:0] ec);
        MIO_ready = rdy;
        #1;
        check({tag, " state"}, 32'(state_dbg), 32'(es));
        check({tag, " ctrl"}, 32'(ctrl_w), 32'(ec));
        @(posedge clk);
        #2;
    endtask

    // Hold reset low for one edge, check outputs, release away from the edge
    task automatic do_reset(input string tag);
        reset     = 1'b0;
        MIO_ready = 1'b0;
        #1;
        check({tag, " state"}, 32'(state_dbg), 32'(S_IF));
        check({tag, " ctrl"}, 32'(ctrl_w), 32'(E_ZERO));
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        MIO_ready = 1'b0;
        zero      = 1'b0;
        Inst      = 32'h0;
        #2;
        do_reset("rst0");

        // lw with two wait cycles in MEM_RD: 7 cycles, RegWrite only in LW_WB
        set_inst(OP_LW, 6'b000000);
        cyc("lw_if",   1'b1, S_IF,       E_IF);
        cyc("lw_id",   1'b0, S_ID,       E_ID);
        cyc("lw_addr", 1'b0, S_MEM_ADDR, E_MADDR);
        cyc("lw_rd0",  1'b0, S_MEM_RD,   E_MRD);
        cyc("lw_rd1",  1'b0, S_MEM_RD,   E_MRD);
        cyc("lw_rd2",  1'b1, S_MEM_RD,   E_MRD);
        cyc("lw_wb",   1'b0, S_LW_WB,    E_LWWB);

        // sw with one wait cycle
        set_inst(OP_SW, 6'b000000);
        cyc("sw_if",   1'b1, S_IF,       E_IF);
        cyc("sw_id",   1'b0, S_ID,       E_ID);
        cyc("sw_addr", 1'b0, S_MEM_ADDR, E_MADDR);
        cyc("sw_wr0",  1'b0, S_MEM_WR,   E_MWR);
        cyc("sw_wr1",  1'b1, S_MEM_WR,   E_MWR);

        // sw abandoned by reset while in MEM_WR
        set_inst(OP_SW, 6'b000000);
        cyc("swr_if",   1'b1, S_IF,       E_IF);
        cyc("swr_id",   1'b0, S_ID,       E_ID);
        cyc("swr_addr", 1'b0, S_MEM_ADDR, E_MADDR);
        MIO_ready = 1'b0;
        #1;
        check("swr_memwrite_before", 32'(MemWrite), 32'd1);
        reset = 1'b0;
        #1;
        check("swr_rst_ctrl", 32'(ctrl_w), 32'(E_ZERO));
        check("swr_rst_state", 32'(state_dbg), 32'(S_IF));
        @(posedge clk);
        #2;
        reset = 1'b1;

        // R-type sub
        set_inst(OP_RTYPE, F_SUB);
        cyc("sub_if",  1'b1, S_IF,    E_IF);
        cyc("sub_id",  1'b0, S_ID,    E_ID);
        cyc("sub_exe", 1'b0, S_R_EXE, E_RSUB);
        cyc("sub_wb",  1'b0, S_R_WB,  E_RWB);

        // R-type srl
        set_inst(OP_RTYPE, F_SRL);
        cyc("srl_if",  1'b1, S_IF,    E_IF);
        cyc("srl_id",  1'b0, S_ID,    E_ID);
        cyc("srl_exe", 1'b0, S_R_EXE, E_RSRL);
        cyc("srl_wb",  1'b0, S_R_WB,  E_RWB);

        // R-type with unsupported funct
        set_inst(OP_RTYPE, 6'b000001);
        cyc("badfn_if", 1'b1, S_IF, E_IF);
        cyc("badfn_id", 1'b0, S_ID, E_ILL);

        // ori and slti
        set_inst(OP_ORI, 6'b010101);
        cyc("ori_if",  1'b1, S_IF,    E_IF);
        cyc("ori_id",  1'b0, S_ID,    E_ID);
        cyc("ori_exe", 1'b0, S_I_EXE, E_IORI);
        cyc("ori_wb",  1'b0, S_I_WB,  E_IWB);
        set_inst(OP_SLTI, 6'b000000);
        cyc("slti_if",  1'b1, S_IF,    E_IF);
        cyc("slti_id",  1'b0, S_ID,    E_ID);
        cyc("slti_exe", 1'b0, S_I_EXE, E_ISLT);
        cyc("slti_wb",  1'b0, S_I_WB,  E_IWB);

        // lui
        set_inst(OP_LUI, 6'b000000);
        cyc("lui_if", 1'b1, S_IF,     E_IF);
        cyc("lui_id", 1'b0, S_ID,     E_ID);
        cyc("lui_wb", 1'b0, S_LUI_WB, E_LUI);

        // beq / bne with zero=1
        zero = 1'b1;
        set_inst(OP_BEQ, 6'b000000);
        cyc("beq_if",  1'b1, S_IF,     E_IF);
        cyc("beq_id",  1'b0, S_ID,     E_ID);
        cyc("beq_br0", 1'b0, S_BRANCH, E_BEQ);
        cyc("beq_br1", 1'b1, S_BRANCH, E_BEQ);
        set_inst(OP_BNE, 6'b000000);
        cyc("bne_if", 1'b1, S_IF,     E_IF);
        cyc("bne_id", 1'b0, S_ID,     E_ID);
        cyc("bne_br", 1'b1, S_BRANCH, E_BNE);
        zero = 1'b0;

        // j
        set_inst(OP_J, 6'b000000);
        cyc("j_if", 1'b1, S_IF,   E_IF);
        cyc("j_id", 1'b0, S_ID,   E_ID);
        cyc("j_jp", 1'b1, S_JUMP, E_JUMP);

        // jal: JAL state when enabled, illegal otherwise
        set_inst(OP_JAL, 6'b000000);
        cyc("jal_if", 1'b1, S_IF, E_IF);
`ifdef M_CTRL_JAL_EN
        cyc("jal_id", 1'b0, S_ID,  E_ID);
        cyc("jal_ex", 1'b1, S_JAL, E_JAL);
`else
        cyc("jal_id", 1'b0, S_ID, E_ILL);
`endif

        // Unknown opcode: one-cycle illegal pulse, back to IF
        set_inst(6'b111111, 6'b111111);
        cyc("op3f_if", 1'b1, S_IF, E_IF);
        cyc("op3f_id", 1'b0, S_ID, E_ILL);

        // Bus timeout in IF: 4 stalled cycles, then HALT held until reset
        cyc("to_if0",  1'b0, S_IF,   E_IF);
        cyc("to_if1",  1'b0, S_IF,   E_IF);
        cyc("to_if2",  1'b0, S_IF,   E_IF);
        cyc("to_if3",  1'b0, S_IF,   E_IF);
        cyc("to_halt0", 1'b0, S_HALT, E_HALT);
        cyc("to_halt1", 1'b1, S_HALT, E_HALT);
        cyc("to_halt2", 1'b1, S_HALT, E_HALT);
        do_reset("to_rst");
        cyc("post_rst_if", 1'b0, S_IF, E_IF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
